cache_l2_control: RTL and testbench

Control FSM for the two-way, write-back L2 cache datapath, `cache_l2_datapath`. It accepts line-sized read and write requests from the L1/arbiter side. It sequences the datapath's array reads and loads, LRU/dirty updates, mux selects and physical-memory handshakes for hits, clean misses and dirty evictions. It also keeps saturating hit/miss/writeback counters for performance reporting.

---
 rtl/cache_l2_control.sv | 160 ++++++++++++++++
 tb/tb_cache_l2_control.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_l2_control.sv
// cache_l2_control: control FSM for the two-way write-back L2 cache datapath.
// It sequences array reads and loads, LRU/dirty updates, mux selects and the
// physical-memory handshakes for hits, clean misses and dirty evictions. It
// also keeps saturating hit/miss/writeback counters.
module cache_l2_control #(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic             eviction,
  output logic             array_read,
  output logic             array_load,
  output logic             lru_load,
  output logic             pmdr_load,
  output logic             dirty_load,
  output logic             datawritemux_sel,
  output logic             adaptermux_sel,
  output logic             pmemaddrmux_sel,
  output logic             prefetch,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             ctr_clear,
  output logic [CTR_W-1:0] hit_count,
  output logic [CTR_W-1:0] miss_count,
  output logic [CTR_W-1:0] wb_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FETCH,
    FILL
  } state_t;

  state_t state, state_next;
  logic   retry;
  logic   hit_inc, miss_inc, wb_inc;

  // A simultaneous read and write is handled as a write.
  logic   is_write;
  assign is_write = mem_write;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Retry marks the LOOKUP that follows a write fill, so its hit is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              retry <= 1'b0;
    else if (state == FILL && is_write)      retry <= 1'b1;
    else if (state == LOOKUP)                retry <= 1'b0;
  end

  // Next-state and all datapath controls, decoded from state and live inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_next       = state;
    mem_resp         = 1'b0;
    array_read       = 1'b0;
    array_load       = 1'b0;
    lru_load         = 1'b0;
    pmdr_load        = 1'b0;
    dirty_load       = 1'b0;
    datawritemux_sel = 1'b0;
    adaptermux_sel   = 1'b0;
    pmemaddrmux_sel  = 1'b0;
    prefetch         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    wb_inc           = 1'b0;

    unique case (state)
      IDLE: begin
        array_read = 1'b1;
        if (mem_read || mem_write) state_next = LOOKUP;
      end

      LOOKUP: begin
        array_read = 1'b1;
        if (hit) begin
          mem_resp = 1'b1;
          lru_load = 1'b1;
          hit_inc  = !retry;
          if (is_write) begin
            array_load       = 1'b1;
            dirty_load       = 1'b1;
            datawritemux_sel = 1'b1;
          end
          state_next = IDLE;
        end else begin
          miss_inc   = 1'b1;
          state_next = eviction ? WRITEBACK : FETCH;
        end
      end

      WRITEBACK: begin
        pmem_write      = 1'b1;
        pmemaddrmux_sel = 1'b1;
        array_read      = 1'b1;
        if (pmem_resp) begin
          wb_inc     = 1'b1;
          state_next = FETCH;
        end
      end

      FETCH: begin
        pmem_read = 1'b1;
        pmdr_load = pmem_resp;
        if (pmem_resp) state_next = FILL;
      end

      FILL: begin
        array_load = 1'b1;
        dirty_load = 1'b1;
        if (is_write) begin
          // The retried LOOKUP hits the freshly filled way and merges the data.
          state_next = LOOKUP;
        end else begin
          mem_resp       = 1'b1;
          adaptermux_sel = 1'b1;
          lru_load       = 1'b1;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Saturating performance counters; clear wins over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (ctr_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_inc  && hit_count  != '1) hit_count  <= hit_count  + CTR_W'(1);
      if (miss_inc && miss_count != '1) miss_count <= miss_count + CTR_W'(1);
      if (wb_inc   && wb_count   != '1) wb_count   <= wb_count   + CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_l2_control.sv
// tb_cache_l2_control: cycle-by-cycle vector tables for the L2 control FSM,
// plus hand sequences for reset during a fetch and counter saturation.
module tb_cache_l2_control;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read, mem_write, hit, eviction, pmem_resp, ctr_clear;

  // Default-width instance.
  logic mem_resp, array_read, array_load, lru_load, pmdr_load, dirty_load;
  logic datawritemux_sel, adaptermux_sel, pmemaddrmux_sel, prefetch;
  logic pmem_read, pmem_write;
  logic [31:0] hit_count, miss_count, wb_count;

  // Narrow-counter instance sharing the same stimulus.
  logic s_mem_resp, s_array_read, s_array_load, s_lru_load, s_pmdr_load, s_dirty_load;
  logic s_datawritemux_sel, s_adaptermux_sel, s_pmemaddrmux_sel, s_prefetch;
  logic s_pmem_read, s_pmem_write;
  logic [3:0] s_hit_count, s_miss_count, s_wb_count;

  cache_l2_control dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit(hit), .eviction(eviction),
    .array_read(array_read), .array_load(array_load), .lru_load(lru_load),
    .pmdr_load(pmdr_load), .dirty_load(dirty_load),
    .datawritemux_sel(datawritemux_sel), .adaptermux_sel(adaptermux_sel),
    .pmemaddrmux_sel(pmemaddrmux_sel), .prefetch(prefetch),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .ctr_clear(ctr_clear), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  cache_l2_control #(.CTR_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mem_resp), .hit(hit), .eviction(eviction),
    .array_read(s_array_read), .array_load(s_array_load), .lru_load(s_lru_load),
    .pmdr_load(s_pmdr_load), .dirty_load(s_dirty_load),
    .datawritemux_sel(s_datawritemux_sel), .adaptermux_sel(s_adaptermux_sel),
    .pmemaddrmux_sel(s_pmemaddrmux_sel), .prefetch(s_prefetch),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_resp(pmem_resp),
    .ctr_clear(ctr_clear), .hit_count(s_hit_count), .miss_count(s_miss_count),
    .wb_count(s_wb_count)
  );

  always #5 clk = ~clk;

  // Output vector order:
  // prefetch resp ard ald lru pmdr dl dws ams pas prd pwr
  logic [11:0] ctl, ctl_w4;
  assign ctl    = {prefetch, mem_resp, array_read, array_load, lru_load, pmdr_load,
                   dirty_load, datawritemux_sel, adaptermux_sel, pmemaddrmux_sel,
                   pmem_read, pmem_write};
  assign ctl_w4 = {s_prefetch, s_mem_resp, s_array_read, s_array_load, s_lru_load,
                   s_pmdr_load, s_dirty_load, s_datawritemux_sel, s_adaptermux_sel,
                   s_pmemaddrmux_sel, s_pmem_read, s_pmem_write};

  // Expected control vectors (prefetch always 0), hand-derived per state.
  localparam logic [11:0] E_IDLE    = 12'b0_01000000000; // IDLE or LOOKUP miss
  localparam logic [11:0] E_RHIT    = 12'b0_11010000000; // read hit
  localparam logic [11:0] E_WHIT    = 12'b0_11110110000; // write hit
  localparam logic [11:0] E_WB      = 12'b0_01000000101; // WRITEBACK
  localparam logic [11:0] E_FETCH   = 12'b0_00000000010; // FETCH waiting
  localparam logic [11:0] E_FETCH_R = 12'b0_00001000010; // FETCH with pmem_resp
  localparam logic [11:0] E_FILL_R  = 12'b0_10110101000; // FILL for a read
  localparam logic [11:0] E_FILL_W  = 12'b0_00100100000; // FILL for a write

  typedef struct {
    logic        rd;
    logic        wr;
    logic        hit;
    logic        ev;
    logic        presp;
    logic        clr;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   row      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic rd, input logic wr, input logic h, input logic ev,
                     input logic presp, input logic clr, input logic [11:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.hit = h; v.ev = ev; v.presp = presp; v.clr = clr; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance one cycle.
  task automatic run_table(input string seq);
    foreach (tbl[i]) begin
      mem_read  = tbl[i].rd;
      mem_write = tbl[i].wr;
      hit       = tbl[i].hit;
      eviction  = tbl[i].ev;
      pmem_resp = tbl[i].presp;
      ctr_clear = tbl[i].clr;
      @(negedge clk);
      check($sformatf("%s[%0d] ctl", seq, i), 64'(ctl), 64'(tbl[i].exp));
      check($sformatf("%s[%0d] ctl_w4", seq, i), 64'(ctl_w4), 64'(tbl[i].exp));
      @(posedge clk);
      #1;
      row++;
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    {mem_read, mem_write, hit, eviction, pmem_resp, ctr_clear} = '0;

    // Reset state.
    #3;
    check("reset ctl", 64'(ctl), 64'(E_IDLE));
    check("reset hit_count", 64'(hit_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read hit: mem_resp one cycle after the request, adapter mux 0.
    add(1, 0, 0, 0, 0, 0, E_IDLE);
    add(1, 0, 1, 0, 0, 0, E_RHIT);
    add(0, 0, 0, 0, 1, 0, E_IDLE);   // stray pmem_resp in IDLE is ignored
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    run_table("rd_hit");
    check("rd_hit hit_count", 64'(hit_count), 64'd1);
    check("rd_hit miss_count", 64'(miss_count), 64'd0);

    // Clean read miss, memory latency 5.
    add(1, 0, 0, 0, 0, 0, E_IDLE);
    add(1, 0, 0, 0, 0, 0, E_IDLE);   // LOOKUP miss, clean
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, E_FETCH);
    add(1, 0, 0, 0, 1, 0, E_FETCH_R);
    add(1, 0, 0, 0, 0, 0, E_FILL_R);
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    run_table("rd_miss");
    check("rd_miss miss_count", 64'(miss_count), 64'd1);
    check("rd_miss wb_count", 64'(wb_count), 64'd0);
    check("rd_miss hit_count", 64'(hit_count), 64'd1);

    // Write miss with dirty victim: WRITEBACK, FETCH, FILL, retried LOOKUP hit.
    add(0, 1, 0, 0, 0, 1, E_IDLE);   // counters cleared here
    add(0, 1, 0, 1, 0, 0, E_IDLE);   // LOOKUP miss, dirty
    add(0, 1, 0, 0, 0, 0, E_WB);
    add(0, 1, 0, 0, 0, 0, E_WB);
    add(0, 1, 0, 0, 1, 0, E_WB);
    add(0, 1, 0, 0, 0, 0, E_FETCH);
    add(0, 1, 0, 0, 1, 0, E_FETCH_R);
    add(0, 1, 0, 0, 0, 0, E_FILL_W);
    add(0, 1, 1, 0, 0, 0, E_WHIT);
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    run_table("wr_miss");
    check("wr_miss hit_count", 64'(hit_count), 64'd0);
    check("wr_miss miss_count", 64'(miss_count), 64'd1);
    check("wr_miss wb_count", 64'(wb_count), 64'd1);

    // Read and write together on a hit behave as a write hit.
    add(1, 1, 0, 0, 0, 0, E_IDLE);
    add(1, 1, 1, 0, 0, 0, E_WHIT);
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    run_table("rw_hit");
    check("rw_hit hit_count", 64'(hit_count), 64'd1);

    // Reset asserted mid-FETCH: pmem_read drops at once, counters clear.
    add(1, 0, 0, 0, 0, 0, E_IDLE);
    add(1, 0, 0, 0, 0, 0, E_IDLE);
    run_table("rst_pre");
    @(negedge clk);
    check("fetch pmem_read", 64'(pmem_read), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst pmem_read", 64'(pmem_read), 64'd0);
    check("rst ctl", 64'(ctl), 64'(E_IDLE));
    check("rst miss_count", 64'(miss_count), 64'd0);
    check("rst hit_count", 64'(hit_count), 64'd0);
    @(negedge clk);
    mem_read = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    add(1, 0, 0, 0, 0, 0, E_IDLE);
    add(1, 0, 1, 0, 0, 0, E_RHIT);
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    run_table("rst_post");
    check("rst_post hit_count", 64'(hit_count), 64'd1);
    check("rst_post wb_count", 64'(wb_count), 64'd0);

    // Saturation: 20 back-to-back hits on the 4-bit counters.
    add(0, 0, 0, 0, 0, 1, E_IDLE);
    for (int i = 0; i < 20; i++) begin
      add(1, 0, 0, 0, 0, 0, E_IDLE);
      add(1, 0, 1, 0, 0, 0, E_RHIT);
    end
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    run_table("sat");
    check("sat w4 hit_count", 64'(s_hit_count), 64'd15);
    check("sat w32 hit_count", 64'(hit_count), 64'd20);
    check("sat w4 miss_count", 64'(s_miss_count), 64'd0);

    // Clear in the same cycle as a counted hit leaves zero.
    add(1, 0, 0, 0, 0, 0, E_IDLE);
    add(1, 0, 1, 0, 0, 1, E_RHIT);
    add(0, 0, 0, 0, 0, 0, E_IDLE);
    run_table("clr_hit");
    check("clr_hit w4 hit_count", 64'(s_hit_count), 64'd0);
    check("clr_hit w32 hit_count", 64'(hit_count), 64'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
